// File: rtl/bus_reg_pkg.sv
// rtl/bus_reg_pkg.sv - shared access-mode encodings and parameter checks for bus_reg_array
package bus_reg_pkg;

  typedef enum logic [1:0] {
    ACC_RW  = 2'd0,
    ACC_W1C = 2'd1,
    ACC_RO  = 2'd2
  } acc_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit bus_width_ok(input int w);
    return (w == 8) || (w == 16) || (w == 32);
  endfunction

  function automatic bit read_latency_ok(input int l);
    return (l == 1) || (l == 2);
  endfunction

endpackage

// File: rtl/bus_reg_rd_pipe.sv
// rtl/bus_reg_rd_pipe.sv - fixed-latency read return pipeline (valid/data/err)
module bus_reg_rd_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             err_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             err_o
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] e_q;
  logic [WIDTH-1:0] d_q [DEPTH];

  // Data only advances with a valid beat so the output holds the last read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_q <= '0;
      e_q <= '0;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= '0;
    end else begin
      v_q[0] <= valid_i;
      e_q[0] <= valid_i & err_i;
      if (valid_i) d_q[0] <= data_i;
      for (int k = 1; k < DEPTH; k++) begin
        v_q[k] <= v_q[k-1];
        e_q[k] <= e_q[k-1];
        if (v_q[k-1]) d_q[k] <= d_q[k-1];
      end
    end
  end

  assign valid_o = v_q[DEPTH-1];
  assign data_o  = d_q[DEPTH-1];
  assign err_o   = e_q[DEPTH-1];

endmodule

// File: rtl/bus_reg_array.sv
// rtl/bus_reg_array.sv - parametrised RW/W1C/RO register file on a simple CPU bus
module bus_reg_array
  import bus_reg_pkg::*;
#(
  parameter int                          BUS_WIDTH    = 16,
  parameter int                          NUM_REGS     = 8,
  parameter int                          ADDR_WIDTH   = 4,
  parameter int                          READ_LATENCY = 1,
  parameter logic [NUM_REGS-1:0]         RW_MASK      = '1,
  parameter logic [NUM_REGS-1:0]         W1C_MASK     = '0,
  parameter logic [NUM_REGS*BUS_WIDTH-1:0] INIT_VALUES = '0
) (
  input  logic                          i_Bus_Clk,
  input  logic                          i_Bus_Rst,
  input  logic                          i_Bus_CS,
  input  logic                          i_Bus_Wr_Rd_n,
  input  logic [ADDR_WIDTH-1:0]         i_Bus_Addr8,
  input  logic [BUS_WIDTH-1:0]          i_Bus_Wr_Data,
  output logic [BUS_WIDTH-1:0]          o_Bus_Rd_Data,
  output logic                          o_Bus_Rd_DV,
  output logic                          o_Bus_Rd_Err,
  input  logic [NUM_REGS*BUS_WIDTH-1:0] i_Reg_In,
  input  logic [NUM_REGS*BUS_WIDTH-1:0] i_Reg_Set,
  output logic [NUM_REGS*BUS_WIDTH-1:0] o_Reg_Out,
  output logic [NUM_REGS-1:0]           o_Reg_Wr_Pulse
);

  localparam int OFF  = clog2(BUS_WIDTH / 8);
  localparam int IDXW = ADDR_WIDTH - OFF;

  if (!bus_width_ok(BUS_WIDTH)) begin : g_bad_bus_width
    $error("bus_reg_array: BUS_WIDTH must be 8, 16 or 32");
  end
  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_read_latency
    $error("bus_reg_array: READ_LATENCY must be 1 or 2");
  end
  if ((RW_MASK & W1C_MASK) != '0) begin : g_bad_masks
    $error("bus_reg_array: RW_MASK and W1C_MASK overlap");
  end

  logic [IDXW-1:0] idx;
  logic            in_range;
  logic            wr_cmd;
  logic            rd_cmd;

  assign idx      = i_Bus_Addr8[ADDR_WIDTH-1:OFF];
  assign in_range = 32'(idx) < NUM_REGS;
  assign wr_cmd   = i_Bus_CS & i_Bus_Wr_Rd_n & in_range;
  assign rd_cmd   = i_Bus_CS & ~i_Bus_Wr_Rd_n;

  if (OFF > 0) begin : g_byte_off
    logic unused_byte_off;
    assign unused_byte_off = ^i_Bus_Addr8[OFF-1:0];
  end

  logic [BUS_WIDTH-1:0] cur_val [NUM_REGS];
  logic [NUM_REGS-1:0]  pulse_d, pulse_q;

  for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg
    localparam acc_e MODE = RW_MASK[n] ? ACC_RW : (W1C_MASK[n] ? ACC_W1C : ACC_RO);
    logic hit;
    assign hit        = wr_cmd && (32'(idx) == n);
    assign pulse_d[n] = hit;

    if (MODE == ACC_RO) begin : g_ro
      logic unused_set;
      assign unused_set = ^i_Reg_Set[n*BUS_WIDTH +: BUS_WIDTH];
      assign cur_val[n] = i_Reg_In[n*BUS_WIDTH +: BUS_WIDTH];
      assign o_Reg_Out[n*BUS_WIDTH +: BUS_WIDTH] = '0;
    end else begin : g_store
      logic [BUS_WIDTH-1:0] reg_q, reg_d;
      logic                 unused_in;
      assign unused_in = ^i_Reg_In[n*BUS_WIDTH +: BUS_WIDTH];

      // W1C: the clear is applied before the OR so a coincident event wins.
      always_comb begin
        reg_d = reg_q;
        if (MODE == ACC_RW) begin
          if (hit) reg_d = i_Bus_Wr_Data;
        end else begin
          reg_d = (reg_q & ~(hit ? i_Bus_Wr_Data : '0)) | i_Reg_Set[n*BUS_WIDTH +: BUS_WIDTH];
        end
      end

      if (MODE == ACC_RW) begin : g_rw_set
        logic unused_set;
        assign unused_set = ^i_Reg_Set[n*BUS_WIDTH +: BUS_WIDTH];
      end

      always_ff @(posedge i_Bus_Clk or posedge i_Bus_Rst) begin
        if (i_Bus_Rst) reg_q <= INIT_VALUES[n*BUS_WIDTH +: BUS_WIDTH];
        else           reg_q <= reg_d;
      end

      assign cur_val[n] = reg_q;
      assign o_Reg_Out[n*BUS_WIDTH +: BUS_WIDTH] = reg_q;
    end
  end

  logic [BUS_WIDTH-1:0] rd_data;
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (32'(idx) == k) rd_data = cur_val[k];
    end
  end

  always_ff @(posedge i_Bus_Clk or posedge i_Bus_Rst) begin
    if (i_Bus_Rst) pulse_q <= '0;
    else           pulse_q <= pulse_d;
  end
  assign o_Reg_Wr_Pulse = pulse_q;

  bus_reg_rd_pipe #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (READ_LATENCY)
  ) u_rd_pipe (
    .clk_i   (i_Bus_Clk),
    .rst_i   (i_Bus_Rst),
    .valid_i (rd_cmd),
    .data_i  (rd_data),
    .err_i   (~in_range),
    .valid_o (o_Bus_Rd_DV),
    .data_o  (o_Bus_Rd_Data),
    .err_o   (o_Bus_Rd_Err)
  );

endmodule

// File: tb/tb_bus_reg_array.sv
// tb/tb_bus_reg_array.sv - directed self-checking bench for bus_reg_array
module tb_bus_reg_array;

  localparam logic [127:0] A_INIT = 128'h0000_0000_0000_0000_0000_A5A5_0000_0000;
  localparam logic [159:0] B_INIT = {32'h5555_0004, 32'h5555_0003, 32'h5555_0002,
                                     32'h5555_0001, 32'h5555_0000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Config A: 8 x 16, latency 1, slot 1 W1C, slot 4 RO, rest RW.
  logic         a_rst, a_cs, a_wr;
  logic [3:0]   a_addr;
  logic [15:0]  a_wdata, a_rdata;
  logic         a_dv, a_err;
  logic [127:0] a_in, a_set, a_out;
  logic [7:0]   a_pulse;

  bus_reg_array #(
    .BUS_WIDTH(16), .NUM_REGS(8), .ADDR_WIDTH(4), .READ_LATENCY(1),
    .RW_MASK(8'b1110_1101), .W1C_MASK(8'b0000_0010), .INIT_VALUES(A_INIT)
  ) dut_a (
    .i_Bus_Clk(clk), .i_Bus_Rst(a_rst), .i_Bus_CS(a_cs), .i_Bus_Wr_Rd_n(a_wr),
    .i_Bus_Addr8(a_addr), .i_Bus_Wr_Data(a_wdata), .o_Bus_Rd_Data(a_rdata),
    .o_Bus_Rd_DV(a_dv), .o_Bus_Rd_Err(a_err), .i_Reg_In(a_in), .i_Reg_Set(a_set),
    .o_Reg_Out(a_out), .o_Reg_Wr_Pulse(a_pulse)
  );

  // Config B: 5 x 32, latency 2, all RW.
  logic         b_rst, b_cs, b_wr;
  logic [4:0]   b_addr;
  logic [31:0]  b_wdata, b_rdata;
  logic         b_dv, b_err;
  logic [159:0] b_in, b_set, b_out;
  logic [4:0]   b_pulse;

  bus_reg_array #(
    .BUS_WIDTH(32), .NUM_REGS(5), .ADDR_WIDTH(5), .READ_LATENCY(2),
    .RW_MASK(5'b11111), .W1C_MASK(5'b00000), .INIT_VALUES(B_INIT)
  ) dut_b (
    .i_Bus_Clk(clk), .i_Bus_Rst(b_rst), .i_Bus_CS(b_cs), .i_Bus_Wr_Rd_n(b_wr),
    .i_Bus_Addr8(b_addr), .i_Bus_Wr_Data(b_wdata), .o_Bus_Rd_Data(b_rdata),
    .o_Bus_Rd_DV(b_dv), .o_Bus_Rd_Err(b_err), .i_Reg_In(b_in), .i_Reg_Set(b_set),
    .o_Reg_Out(b_out), .o_Reg_Wr_Pulse(b_pulse)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_cmd(input logic wr, input logic [3:0] addr, input logic [15:0] data);
    a_cs = 1'b1; a_wr = wr; a_addr = addr; a_wdata = data;
    tick();
    a_cs = 1'b0; a_wr = 1'b0;
  endtask

  task automatic b_cmd(input logic wr, input logic [4:0] addr, input logic [31:0] data);
    b_cs = 1'b1; b_wr = wr; b_addr = addr; b_wdata = data;
    tick();
    b_cs = 1'b0; b_wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_rst = 1'b1; a_cs = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0; a_in = '0; a_set = '0;
    b_rst = 1'b1; b_cs = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0; b_in = '0; b_set = '0;
    #3;
    chk("a_rst_data", a_rdata, 0);
    chk("a_rst_dv", a_dv, 0);
    chk("a_rst_err", a_err, 0);
    chk("a_rst_pulse", a_pulse, 0);
    chk("a_rst_init_slot2", a_out[47:32], 16'hA5A5);
    chk("b_rst_dv", b_dv, 0);
    chk("b_rst_out", b_out, B_INIT);
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0;
    tick();

    a_cmd(1'b0, 4'd4, 16'h0);
    chk("a_rd_init_dv", a_dv, 1);
    chk("a_rd_init_data", a_rdata, 16'hA5A5);
    chk("a_rd_init_err", a_err, 0);
    tick();
    chk("a_rd_init_dv_off", a_dv, 0);
    chk("a_rd_hold_data", a_rdata, 16'hA5A5);

    a_cmd(1'b1, 4'd6, 16'h1234);
    chk("a_wr_out_slot3", a_out[63:48], 16'h1234);
    chk("a_wr_pulse", a_pulse, 8'h08);
    tick();
    chk("a_wr_pulse_off", a_pulse, 8'h00);
    a_cmd(1'b0, 4'd7, 16'h0);
    chk("a_rd_slot3_dv", a_dv, 1);
    chk("a_rd_slot3_data", a_rdata, 16'h1234);

    a_set[31:16] = 16'h0011;
    tick();
    a_set = '0;
    chk("a_w1c_set_out", a_out[31:16], 16'h0011);
    a_cmd(1'b0, 4'd2, 16'h0);
    chk("a_w1c_rd_set", a_rdata, 16'h0011);
    a_cmd(1'b1, 4'd2, 16'h0001);
    chk("a_w1c_clr_out", a_out[31:16], 16'h0010);
    chk("a_w1c_clr_pulse", a_pulse, 8'h02);
    a_cmd(1'b0, 4'd2, 16'h0);
    chk("a_w1c_rd_clr", a_rdata, 16'h0010);
    a_set[31:16] = 16'h0010;
    a_cmd(1'b1, 4'd2, 16'h0010);
    a_set = '0;
    chk("a_w1c_setwins_out", a_out[31:16], 16'h0010);
    a_cmd(1'b0, 4'd2, 16'h0);
    chk("a_w1c_setwins_rd", a_rdata, 16'h0010);

    a_in[79:64] = 16'hBEEF;
    a_cmd(1'b0, 4'd8, 16'h0);
    chk("a_ro_rd", a_rdata, 16'hBEEF);
    chk("a_ro_out_zero", a_out[79:64], 16'h0000);
    a_cmd(1'b1, 4'd8, 16'h0000);
    chk("a_ro_wr_pulse", a_pulse, 8'h10);
    tick();
    a_cmd(1'b0, 4'd8, 16'h0);
    chk("a_ro_rd_after_wr", a_rdata, 16'hBEEF);

    b_cmd(1'b0, 5'd28, 32'h0);
    chk("b_oor_dv_early", b_dv, 0);
    tick();
    chk("b_oor_dv", b_dv, 1);
    chk("b_oor_data", b_rdata, 32'h0);
    chk("b_oor_err", b_err, 1);
    tick();
    chk("b_oor_dv_off", b_dv, 0);
    chk("b_oor_err_off", b_err, 0);

    b_cmd(1'b1, 5'd24, 32'hFFFF_FFFF);
    chk("b_oor_wr_pulse", b_pulse, 5'h00);
    chk("b_oor_wr_out", b_out, B_INIT);

    b_cs = 1'b1; b_wr = 1'b0; b_addr = 5'd0;
    tick();
    chk("b_b2b_dv_early", b_dv, 0);
    b_addr = 5'd4;
    tick();
    chk("b_b2b_dv0", b_dv, 1);
    chk("b_b2b_data0", b_rdata, 32'h5555_0000);
    b_addr = 5'd8;
    tick();
    b_cs = 1'b0;
    chk("b_b2b_dv1", b_dv, 1);
    chk("b_b2b_data1", b_rdata, 32'h5555_0001);
    b_rst = 1'b1;
    #1;
    chk("b_rst_mid_dv", b_dv, 0);
    chk("b_rst_mid_data", b_rdata, 32'h0);
    tick(); tick();
    b_rst = 1'b0;
    tick();
    chk("b_post_rst_dv_a", b_dv, 0);
    tick();
    chk("b_post_rst_dv_b", b_dv, 0);
    tick();
    chk("b_post_rst_dv_c", b_dv, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
